// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : muldiv_pkg
// Description : Shared encodings and constants for the HI/LO multiply/divide
//               sequencer and its radix-2 iteration step.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // Iteration count of the radix-2 engine; equals the operand width.
  localparam int STEPS = 32;

  // Quotient produced when the divisor is zero.
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // Decoder operation encoding.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational radix-2 iteration. Multiply mode performs
//               a shift-add on {product_hi, multiplier}; divide mode performs
//               a restoring shift-subtract on {remainder, dividend/quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,   // 1: divide iteration, 0: multiply
  input  logic [2*WIDTH-1:0] i_acc,   // current accumulator
  input  logic [WIDTH-1:0]   i_opnd,  // multiplicand or divisor magnitude
  output logic [2*WIDTH-1:0] o_acc,   // next accumulator (divide: LSB left 0)
  output logic               o_qbit   // quotient bit, divide mode only
);

  logic [WIDTH:0] w_sum;   // multiply: upper half plus optional addend
  logic [WIDTH:0] w_part;  // divide: partial remainder shifted left by one
  logic [WIDTH:0] w_diff;  // divide: trial subtraction; MSB set means borrow

  // Evaluate both iteration flavours and select by mode.
  always_comb begin
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
             (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    w_part = i_acc[2*WIDTH-1:WIDTH-1];
    // The shifted remainder is below twice the divisor, so a non-negative
    // difference always fits in WIDTH bits and bit WIDTH flags the borrow.
    w_diff = w_part - {1'b0, i_opnd};
    o_qbit = 1'b0;
    o_acc  = {w_sum, i_acc[WIDTH-1:1]};
    if (i_div) begin
      o_qbit = ~w_diff[WIDTH];
      if (o_qbit) begin
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end else begin
        o_acc = {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_sequencer
// Description : Multi-cycle MIPS HI/LO unit executing MULT, MULTU, DIV and
//               DIVU on an iterative radix-2 engine. Stalls MFHI/MFLO while a
//               result is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = muldiv_pkg::STEPS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             readHiLo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             divZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(STEPS);

  state_e               r_state;
  state_e               w_next;
  op_e                  r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div;
  logic                 r_div0;
  logic                 r_neg_lo;   // negate product / quotient
  logic                 r_neg_hi;   // negate remainder
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_dz;

  logic                 w_signed;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_step_acc;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  // Single radix-2 iteration shared by multiply and divide.
  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_div  (r_is_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_qbit (w_qbit)
  );

  // Operand sign decode and magnitudes, consumed in PREP.
  always_comb begin
    w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    w_sa     = w_signed & r_a[WIDTH-1];
    w_sb     = w_signed & r_b[WIDTH-1];
    w_mag_a  = w_sa ? -r_a : r_a;
    w_mag_b  = w_sb ? -r_b : r_b;
  end

  // Sign fix-up of the finished accumulator; divide-by-zero bypasses it.
  always_comb begin
    w_prod   = r_neg_lo ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_a;
        w_res_lo = WIDTH'(DIV0_QUOTIENT);
      end else begin
        w_res_hi = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res_lo = r_neg_lo ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> PREP -> RUN (STEPS cycles) -> FIX -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PREP;
      S_PREP:  w_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, preparation and iteration datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= OP_MULT;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= op_e'(op);
            r_a  <= opA;
            r_b  <= opB;
          end
        end
        S_PREP: begin
          r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
          r_opnd   <= w_mag_b;
          r_cnt    <= CNT_W'(STEPS - 1);
          r_is_div <= r_op[1];
          r_div0   <= r_op[1] & (r_b == '0);
          r_neg_lo <= w_sa ^ w_sb;
          r_neg_hi <= w_sa;
        end
        S_RUN: begin
          r_acc <= w_step_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO registers and the completion pulses, updated on leaving FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      r_dz   <= (r_state == S_FIX) & r_is_div & r_div0;
      if (r_state == S_FIX) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign stall   = readHiLo & (busy | (start & (r_state == S_IDLE)));
  assign done    = r_done;
  assign divZero = r_dz;
  assign Hi      = r_hi;
  assign Lo      = r_lo;

endmodule : hilo_muldiv_sequencer
`default_nettype wire
